// File: rtl/life_engine_param.sv
// life_engine_param
//   Parametrised Game-of-Life engine for a 2^LOG_W x 2^LOG_H board, one cell
//   evaluated per clock. Topology (toroidal / dead edge) and the B/S rule masks
//   are chosen per STEP. The next generation is built in a shadow board and
//   copied to the visible board in one cycle, gated by a display-safe strobe,
//   so readers never see a half-evaluated generation.
//
//   Optional feature: define LIFE_STILL_DETECT_EN to enable still-life detection
//   (stable=1 after a STEP in which no cell changed). Undefined: stable tied 0.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_op                  0=STEP 1=CLEAR 2=RANDOM 3=NOP
//   rnd_bit                 random source written cell by cell during RANDOM
//   commit_ok               strobe that allows the shadow board to be committed
//   wrap_en                 1=toroidal, 0=cells outside the board are dead
//   birth_mask/survive_mask bit n: birth / survival with n live neighbours
//   wr_en/wr_addr/wr_data   host single-cell write {row,col}, IDLE only
//   rd_addr/rd_data         combinational read of the committed board
//   busy, done              ~cmd_ready; one-cycle completion pulse
//   generation              steps since last CLEAR/RANDOM
//   alive_count             live cells in the committed board
//   stable                  still-life indication (see above)
module life_engine_param #(
   parameter int LOG_W = 3,
   parameter int LOG_H = 3,
   parameter int GEN_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic                   rnd_bit,
   input  logic                   commit_ok,
   input  logic                   wrap_en,
   input  logic [8:0]             birth_mask,
   input  logic [8:0]             survive_mask,
   input  logic                   wr_en,
   input  logic [LOG_W+LOG_H-1:0] wr_addr,
   input  logic                   wr_data,
   input  logic [LOG_W+LOG_H-1:0] rd_addr,
   output logic                   rd_data,
   output logic                   busy,
   output logic                   done,
   output logic [GEN_W-1:0]       generation,
   output logic [LOG_W+LOG_H:0]   alive_count,
   output logic                   stable
);

   localparam int A = LOG_W + LOG_H;
   localparam int N = 1 << A;

   localparam logic [1:0] OP_STEP   = 2'd0;
   localparam logic [1:0] OP_CLEAR  = 2'd1;
   localparam logic [1:0] OP_RANDOM = 2'd2;
   localparam logic [1:0] OP_NOP    = 2'd3;

   typedef enum logic [1:0] {IDLE, EVAL, COMMIT, FILL} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     board_q;
   logic [N-1:0]     next_q;
   logic [A-1:0]     idx_q;
   logic [A:0]       live_acc_q;
   logic             wrap_q;
   logic [8:0]       birth_q;
   logic [8:0]       survive_q;
   logic             done_d;
   logic             accept;
   logic             idx_last;
   logic [LOG_H-1:0] row;
   logic [LOG_W-1:0] col;
   logic [LOG_H:0]   nb_row;
   logic [LOG_W:0]   nb_col;
   logic [3:0]       nsum;
   logic             cur_cell;
   logic             new_cell;

   assign cmd_ready = (state_q == IDLE);
   assign busy      = ~cmd_ready;
   assign accept    = cmd_valid & cmd_ready;
   assign idx_last  = &idx_q;
   assign rd_data   = board_q[rd_addr];
   assign row       = idx_q[A-1:LOG_W];
   assign col       = idx_q[LOG_W-1:0];
   assign cur_cell  = board_q[idx_q];

   // Neighbour coordinates are formed one bit wider than the board so that
   // stepping off either edge (to -1 or to the size) sets the extra bit: the
   // low bits are then the toroidal wrap, and the extra bit marks a dead cell.
   always_comb begin
      nsum   = '0;
      nb_row = '0;
      nb_col = '0;
      for (int dy = 0; dy < 3; dy++) begin
         for (int dx = 0; dx < 3; dx++) begin
            nb_row = {1'b0, row} + (LOG_H+1)'(dy) - (LOG_H+1)'(1);
            nb_col = {1'b0, col} + (LOG_W+1)'(dx) - (LOG_W+1)'(1);
            if (!(dy == 1 && dx == 1)) begin
               nsum = nsum + 4'(board_q[{nb_row[LOG_H-1:0], nb_col[LOG_W-1:0]}]
                               & (wrap_q | ~(nb_row[LOG_H] | nb_col[LOG_W])));
            end
         end
      end
   end

   assign new_cell = cur_cell ? survive_q[nsum] : birth_q[nsum];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_STEP:   state_d = EVAL;
                  OP_RANDOM: state_d = FILL;
                  OP_CLEAR,
                  OP_NOP:    done_d  = 1'b1;
                  default:   done_d  = 1'b1;
               endcase
            end
         end
         EVAL: begin
            if (idx_last) state_d = COMMIT;
         end
         COMMIT: begin
            if (commit_ok) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         FILL: begin
            if (idx_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Board, counters and the per-STEP snapshot of topology and rules.
   // A host write only lands when no command is accepted in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         board_q     <= '0;
         next_q      <= '0;
         idx_q       <= '0;
         live_acc_q  <= '0;
         wrap_q      <= 1'b0;
         birth_q     <= '0;
         survive_q   <= '0;
         done        <= 1'b0;
         generation  <= '0;
         alive_count <= '0;
      end else begin
         done <= done_d;
         case (state_q)
            IDLE: begin
               idx_q      <= '0;
               live_acc_q <= '0;
               if (accept) begin
                  case (cmd_op)
                     OP_STEP: begin
                        wrap_q    <= wrap_en;
                        birth_q   <= birth_mask;
                        survive_q <= survive_mask;
                     end
                     OP_CLEAR: begin
                        board_q     <= '0;
                        alive_count <= '0;
                        generation  <= '0;
                     end
                     OP_RANDOM: generation <= '0;
                     default: ;
                  endcase
               end else if (wr_en && (board_q[wr_addr] != wr_data)) begin
                  board_q[wr_addr] <= wr_data;
                  alive_count      <= wr_data ? alive_count + 1'b1 : alive_count - 1'b1;
               end
            end
            EVAL: begin
               next_q[idx_q] <= new_cell;
               live_acc_q    <= live_acc_q + (A+1)'(new_cell);
               idx_q         <= idx_q + 1'b1;
            end
            COMMIT: begin
               if (commit_ok) begin
                  board_q     <= next_q;
                  alive_count <= live_acc_q;
                  generation  <= generation + 1'b1;
               end
            end
            FILL: begin
               board_q[idx_q] <= rnd_bit;
               live_acc_q     <= live_acc_q + (A+1)'(rnd_bit);
               idx_q          <= idx_q + 1'b1;
               if (idx_last) alive_count <= live_acc_q + (A+1)'(rnd_bit);
            end
            default: ;
         endcase
      end
   end

`ifdef LIFE_STILL_DETECT_EN
   logic changed_q;
   logic stable_q;

   // changed_q collects any cell flip during EVAL; it becomes the stable flag
   // only when the generation is actually committed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         changed_q <= 1'b0;
         stable_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  changed_q <= 1'b0;
                  if (cmd_op == OP_CLEAR || cmd_op == OP_RANDOM) stable_q <= 1'b0;
               end else if (wr_en && (board_q[wr_addr] != wr_data)) begin
                  stable_q <= 1'b0;
               end
            end
            EVAL: begin
               if (new_cell != cur_cell) changed_q <= 1'b1;
            end
            COMMIT: begin
               if (commit_ok) stable_q <= ~changed_q;
            end
            default: ;
         endcase
      end
   end

   assign stable = stable_q;
`else
   assign stable = 1'b0;
`endif

endmodule
